// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// It blanks anodes at each slot start, updates data only at frame boundaries, and can suppress leading zeros.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] din,
    input  logic [7:0]  dp,
    input  logic        lz_en,
    output logic [7:0]  seg_n,
    output logic [7:0]  an_n
);

    localparam int unsigned CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DIGITS   = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned NIB_W    = 4;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp;
    } disp_t;

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        hex7 = 7'h00;
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            4'hF: hex7 = 7'h71;
            default: hex7 = 7'h00;
        endcase
    endfunction

    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    disp_t            pend_q;
    disp_t            disp_q;

    logic             slot_wrap;
    logic             frame_wrap;
    disp_t            din_pkt;

    logic [NIB_W-1:0] nib [DIGITS];
    logic [DIGITS-1:0] lz_blank;
    logic             zero_run;

    logic [7:0]       seg_d;
    logic [7:0]       an_d;

    assign slot_wrap  = (cnt_q == CNT_LAST);
    assign frame_wrap = slot_wrap && (idx_q == IDX_LAST);
    assign din_pkt    = '{data: din, dp: dp};

    // Slot counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (slot_wrap) begin
            cnt_q <= '0;
            idx_q <= idx_q + IDX_W'(1);
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Pending capture; the latest load wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else if (load) begin
            pend_q <= din_pkt;
        end
    end

    // Frame-synchronous display update, bypassing pending when a load lands on the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
        end else if (frame_wrap) begin
            disp_q <= load ? din_pkt : pend_q;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(DIGITS); k++) begin
            nib[k] = disp_q.data[NIB_W*k +: NIB_W];
        end
    end

    // Digit k>0 is blank when it and every more-significant nibble are zero.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            zero_run    = zero_run && (nib[k] == 4'h0);
            lz_blank[k] = zero_run;
        end
    end

    always_comb begin
        an_d  = 8'hFF;
        seg_d = 8'hFF;
        if (en && (cnt_q >= CNT_BLANK)) begin
            an_d     = ~(8'b1 << idx_q);
            seg_d[7] = ~disp_q.dp[idx_q];
            if (lz_en && lz_blank[idx_q]) begin
                seg_d[6:0] = 7'h7F;
            end else begin
                seg_d[6:0] = ~hex7(nib[idx_q]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n <= 8'hFF;
            an_n  <= 8'hFF;
        end else begin
            seg_n <= seg_d;
            an_n  <= an_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=8, BLANK_CYCLES=2 (64-cycle frames).
// Edge n after reset release shows the scan state of cycle n-1, so the bench derives slot timing from edge numbers.
module tb_seg7_scan_driver;

    localparam int unsigned SCAN_DIV     = 8;
    localparam int unsigned BLANK_CYCLES = 2;
    localparam int          FRAME        = 64;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [31:0] din;
    logic [7:0]  dp;
    logic        lz_en;
    logic [7:0]  seg_n;
    logic [7:0]  an_n;

    int n_checks;
    int n_fail;
    int edge_n;

    seg7_scan_driver #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .load  (load),
        .din   (din),
        .dp    (dp),
        .lz_en (lz_en),
        .seg_n (seg_n),
        .an_n  (an_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic goto_edge(input int n);
        if (edge_n > n) begin
            n_checks++;
            n_fail++;
            $display("FAIL sequencing: at edge %0d expected edge %0d", edge_n, n);
        end
        while (edge_n < n) tick();
    endtask

    // Check one digit slot: two blank cycles, then active from the third through the eighth cycle.
    task automatic check_digit(input int f, input int k, input logic [7:0] exp_seg);
        int          base;
        logic [7:0]  an_exp;
        base   = FRAME * f + 8 * k;
        an_exp = ~(8'b1 << k);
        goto_edge(base + 1);
        check($sformatf("f%0d_d%0d_blank0_an", f, k), an_n, 8'hFF);
        goto_edge(base + 2);
        check($sformatf("f%0d_d%0d_blank1_an", f, k), an_n, 8'hFF);
        goto_edge(base + 3);
        check($sformatf("f%0d_d%0d_first_an", f, k), an_n, an_exp);
        check($sformatf("f%0d_d%0d_first_seg", f, k), seg_n, exp_seg);
        goto_edge(base + 8);
        check($sformatf("f%0d_d%0d_last_an", f, k), an_n, an_exp);
        check($sformatf("f%0d_d%0d_last_seg", f, k), seg_n, exp_seg);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        edge_n   = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        load     = 1'b0;
        din      = '0;
        dp       = '0;
        lz_en    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_seg", seg_n, 8'hFF);
        check("reset_an", an_n, 8'hFF);

        @(negedge clk);
        rst_n = 1'b1;
        edge_n = 0;

        // Frame 0 still shows the cleared display; 89ABCDEF goes live in frame 1.
        load = 1'b1;
        din  = 32'h89AB_CDEF;
        dp   = 8'h00;
        tick();
        load = 1'b0;
        check_digit(0, 0, 8'hC0);
        check_digit(0, 7, 8'hC0);
        check_digit(1, 0, 8'h8E);
        check_digit(1, 1, 8'h86);

        // Mid-frame load with leading-zero suppression; frame 1 must not tear.
        lz_en = 1'b1;
        load  = 1'b1;
        din   = 32'h0000_0012;
        tick();
        load  = 1'b0;
        check_digit(1, 7, 8'h80);
        check_digit(2, 0, 8'hA4);
        check_digit(2, 1, 8'hF9);
        check_digit(2, 2, 8'hFF);

        load = 1'b1;
        din  = 32'h0000_0000;
        tick();
        load = 1'b0;
        check_digit(2, 7, 8'hFF);
        check_digit(3, 0, 8'hC0);
        check_digit(3, 1, 8'hFF);

        // Load during digit 3 of frame 3: rest of frame 3 stays old.
        goto_edge(218);
        lz_en = 1'b0;
        load  = 1'b1;
        din   = 32'h1234_5678;
        tick();
        load  = 1'b0;
        check_digit(3, 4, 8'hC0);
        check_digit(3, 7, 8'hC0);
        check_digit(4, 0, 8'h80);
        check_digit(4, 3, 8'h92);

        // Load on the exact frame-boundary cycle: bypass into frame 5.
        goto_edge(319);
        load = 1'b1;
        din  = 32'h0000_00A5;
        tick();
        load = 1'b0;
        check_digit(5, 0, 8'h92);
        check_digit(5, 1, 8'h88);
        check_digit(5, 2, 8'hC0);

        // Decimal points on digits 0 and 2 with data 0.
        load = 1'b1;
        din  = 32'h0000_0000;
        dp   = 8'h05;
        tick();
        load = 1'b0;
        dp   = 8'h00;
        check_digit(6, 0, 8'h40);
        check_digit(6, 1, 8'hC0);
        check_digit(6, 2, 8'h40);
        check_digit(6, 3, 8'hC0);

        // Display off for 20 cycles starting in digit 2 of frame 7; scanning keeps phase.
        goto_edge(466);
        en = 1'b0;
        goto_edge(470);
        check("en_off_a_an", an_n, 8'hFF);
        check("en_off_a_seg", seg_n, 8'hFF);
        goto_edge(478);
        check("en_off_b_an", an_n, 8'hFF);
        goto_edge(486);
        check("en_off_c_an", an_n, 8'hFF);
        en = 1'b1;
        goto_edge(487);
        check("en_resume_an", an_n, 8'hEF);
        check("en_resume_seg", seg_n, 8'hC0);
        check_digit(7, 5, 8'hC0);

        // Asynchronous reset in the middle of an active slot of digit 6.
        goto_edge(500);
        check("pre_reset_an", an_n, 8'hBF);
        check("pre_reset_seg", seg_n, 8'hC0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_an", an_n, 8'hFF);
        check("async_reset_seg", seg_n, 8'hFF);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
        dp     = 8'h05;
        goto_edge(1);
        check("restart_e1_an", an_n, 8'hFF);
        goto_edge(2);
        check("restart_e2_an", an_n, 8'hFF);
        goto_edge(3);
        check("restart_e3_an", an_n, 8'hFE);
        check("restart_e3_seg", seg_n, 8'hC0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
